// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the alu, the sequencing FSM and the register-file
// operand stage. Holds the datapath/flag widths, the no-op opcode, the opcode map
// and the bit positions inside the alu flag vector.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int FLAG_W = 5;

  localparam logic [7:0] WAIT_OP = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_MOV  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h06;
  localparam logic [7:0] OP_CMP  = 8'h07;

  // Flag bit indices inside alu_flags / flags_out.
  localparam int FLAG_Z = 0;  // zero
  localparam int FLAG_C = 1;  // carry
  localparam int FLAG_F = 2;  // overflow
  localparam int FLAG_L = 3;  // unsigned less-than
  localparam int FLAG_N = 4;  // negative

  // Request handed from the sequencing FSM to the operand stage.
  typedef struct packed {
    logic [7:0] opcode;
    logic [3:0] rdest;
    logic [3:0] rsrc;
    logic       imm_sel;
    logic       wr_en;
  } op_req_t;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREGS x DATA_W register storage.
//   CLOCK_50/reset_n : clock, async active-low reset (all registers cleared)
//   ra_sel/ra_data   : combinational read port A
//   rb_sel/rb_data   : combinational read port B
//   dbg_sel/dbg_data : combinational debug read port
//   we/wsel/wdata    : synchronous write port (the only way contents change)
module regfile_2r1w import alu_pkg::*; #(
  parameter int NREGS = 16,
  parameter int SEL_W = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [SEL_W-1:0]  ra_sel,
  output logic [DATA_W-1:0] ra_data,
  input  logic [SEL_W-1:0]  rb_sel,
  output logic [DATA_W-1:0] rb_data,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [SEL_W-1:0]  wsel,
  input  logic [DATA_W-1:0] wdata
);
  logic [NREGS-1:0][DATA_W-1:0] rf_q;

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n)                        rf_q[g] <= '0;
      else if (we && wsel == SEL_W'(g))    rf_q[g] <= wdata;
    end
  end

  assign ra_data  = rf_q[ra_sel];
  assign rb_data  = rf_q[rb_sel];
  assign dbg_data = rf_q[dbg_sel];
endmodule

// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe: operand stage in front of the combinational alu.
// Captures a request (S1), presents operands to the alu for one execute cycle,
// then retires: writes the alu result back and latches result/flags.
//   op_valid/opcode/rdest_sel/rsrc_sel/imm_sel/imm_in/wr_en : request in
//   busy                      : request in flight, op_valid ignored
//   alu_a/alu_b/alu_op        : to alu (hold last values while idle)
//   alu_result/alu_flags      : from alu, combinational
//   done                      : 1-cycle retire pulse
//   result_out/flags_out      : last retired non-WAIT result and flags
//   dbg_sel/dbg_data          : combinational register peek (never bypassed)
// Build option: REGFILE_BYPASS_EN -- busy tied low, back-to-back requests,
// retiring result forwarded into a coincident capture.
module regfile_alu_pipe import alu_pkg::*; #(
  parameter int NREGS = 16,
  parameter int SEL_W = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              op_valid,
  input  logic [7:0]        opcode,
  input  logic [SEL_W-1:0]  rdest_sel,
  input  logic [SEL_W-1:0]  rsrc_sel,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              wr_en,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              done,
  output logic [DATA_W-1:0] result_out,
  output logic [FLAG_W-1:0] flags_out,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  logic              v1_q, done_q, we_q;
  logic [7:0]        op_q;
  logic [SEL_W-1:0]  dest_q;
  logic [DATA_W-1:0] a_q, b_q, a_d, b_d, rd_a, rd_b, result_q;
  logic [FLAG_W-1:0] flags_q;
  logic              accept, retire_live, wb_fire;

  // retire_live: retiring op updates result/flags; wb_fire: it also writes rf.
  assign retire_live = v1_q && (op_q != WAIT_OP);
  assign wb_fire     = retire_live && we_q;

`ifdef REGFILE_BYPASS_EN
  assign busy = 1'b0;
`else
  assign busy = v1_q;
`endif
  assign accept = op_valid && !busy;

  regfile_2r1w #(.NREGS(NREGS), .SEL_W(SEL_W)) u_rf (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .ra_sel   (rdest_sel),
    .ra_data  (rd_a),
    .rb_sel   (rsrc_sel),
    .rb_data  (rd_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .we       (wb_fire),
    .wsel     (dest_q),
    .wdata    (alu_result)
  );

  always_comb begin
    a_d = rd_a;
    b_d = imm_sel ? imm_in : rd_b;
`ifdef REGFILE_BYPASS_EN
    // The rf write lands on this same edge, so the read ports are stale by one op.
    if (wb_fire && rdest_sel == dest_q)            a_d = alu_result;
    if (wb_fire && !imm_sel && rsrc_sel == dest_q) b_d = alu_result;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      done_q   <= 1'b0;
      op_q     <= WAIT_OP;
      we_q     <= 1'b0;
      dest_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      v1_q   <= accept;
      done_q <= v1_q;
      if (accept) begin
        a_q    <= a_d;
        b_q    <= b_d;
        op_q   <= opcode;
        dest_q <= rdest_sel;
        we_q   <= wr_en;
      end
      if (retire_live) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign done       = done_q;
  assign result_out = result_q;
  assign flags_out  = flags_q;
endmodule

// File: tb/tb_regfile_alu_pipe.sv
module tb_regfile_alu_pipe;
  import alu_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              CLOCK_50 = 1'b0;
  logic              reset_n;
  logic              op_valid;
  logic [7:0]        opcode;
  logic [3:0]        rdest_sel, rsrc_sel, dbg_sel;
  logic              imm_sel, wr_en;
  logic [DATA_W-1:0] imm_in;
  logic              busy, done;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result, result_out, dbg_data;
  logic [7:0]        alu_op;
  logic [FLAG_W-1:0] alu_flags, flags_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  regfile_alu_pipe #(.NREGS(16), .SEL_W(4)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .op_valid(op_valid), .opcode(opcode),
    .rdest_sel(rdest_sel), .rsrc_sel(rsrc_sel), .imm_sel(imm_sel), .imm_in(imm_in),
    .wr_en(wr_en), .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags), .done(done),
    .result_out(result_out), .flags_out(flags_out), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Behavioural alu: ADD only; any other opcode yields a marker value so a
  // wrongful WAIT writeback is visible.
  logic [DATA_W:0] sum;
  always_comb begin
    sum        = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = 16'hBEEF;
    alu_flags  = '0;
    if (alu_op == OP_ADD) begin
      alu_result        = sum[DATA_W-1:0];
      alu_flags[FLAG_Z] = (sum[DATA_W-1:0] == '0);
      alu_flags[FLAG_C] = sum[DATA_W];
      alu_flags[FLAG_N] = sum[DATA_W-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic is, input logic [15:0] imm, input logic we);
    op_valid = 1'b1; opcode = op; rdest_sel = rd; rsrc_sel = rs;
    imm_sel = is; imm_in = imm; wr_en = we;
  endtask

  task automatic rd_reg(input string tag, input logic [3:0] sel, input logic [15:0] exp);
    dbg_sel = sel;
    #1 chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  // Single request: drive at N0, check operands in execute cycle, done at N2 only.
  task automatic one_op(input string tag, input logic [7:0] op, input logic [3:0] rd,
                        input logic [3:0] rs, input logic is, input logic [15:0] imm,
                        input logic we, input logic [15:0] ea, input logic [15:0] eb);
    @(negedge CLOCK_50); drive(op, rd, rs, is, imm, we);
    @(negedge CLOCK_50); op_valid = 1'b0;
    chk({tag, ".a"},    32'(alu_a), 32'(ea));
    chk({tag, ".b"},    32'(alu_b), 32'(eb));
    chk({tag, ".op"},   32'(alu_op), 32'(op));
    chk({tag, ".busy"}, 32'(busy), 32'(!BYP));
    chk({tag, ".d0"},   32'(done), 32'd0);
    @(negedge CLOCK_50);
    chk({tag, ".d1"},   32'(done), 32'd1);
    @(negedge CLOCK_50);
    chk({tag, ".d2"},   32'(done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; op_valid = 1'b0; opcode = '0; rdest_sel = '0; rsrc_sel = '0;
    imm_sel = 1'b0; imm_in = '0; wr_en = 1'b0; dbg_sel = '0;
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;

    // 1. reset state
    for (int i = 0; i < 16; i++) rd_reg($sformatf("rst.r%0d", i), 4'(i), 16'h0000);
    chk("rst.result", 32'(result_out), 32'h0);
    chk("rst.flags",  32'(flags_out), 32'h0);
    chk("rst.done",   32'(done), 32'h0);
    chk("rst.op",     32'(alu_op), 32'(WAIT_OP));

    // 2. ADD r3 <- r3(0) + 7
    one_op("add_imm", OP_ADD, 4'd3, 4'd0, 1'b1, 16'h0007, 1'b1, 16'h0000, 16'h0007);
    rd_reg("add_imm.r3", 4'd3, 16'h0007);
    chk("add_imm.res", 32'(result_out), 32'h7);

    // 3. same-register operands, then dependent read
    one_op("same", OP_ADD, 4'd3, 4'd3, 1'b0, 16'h0000, 1'b1, 16'h0007, 16'h0007);
    rd_reg("same.r3", 4'd3, 16'h000E);
    one_op("dep", OP_ADD, 4'd4, 4'd3, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h000E);
    rd_reg("dep.r4", 4'd4, 16'h000E);

    // wr_en = 0: result/flags latch, r6 untouched
    one_op("nowr", OP_ADD, 4'd6, 4'd0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF);
    rd_reg("nowr.r6", 4'd6, 16'h0000);
    chk("nowr.res",   32'(result_out), 32'hFFFF);
    chk("nowr.flags", 32'(flags_out), 32'h10);

    // 4. WAIT_OP with wr_en: nothing changes but done pulses
    one_op("wait", WAIT_OP, 4'd4, 4'd3, 1'b1, 16'h1234, 1'b1, 16'h000E, 16'h1234);
    rd_reg("wait.r4", 4'd4, 16'h000E);
    chk("wait.res",   32'(result_out), 32'hFFFF);
    chk("wait.flags", 32'(flags_out), 32'h10);

    // 5. back-to-back requests
    if (!BYP) begin
      @(negedge CLOCK_50); drive(OP_ADD, 4'd7, 4'd0, 1'b1, 16'h0001, 1'b1);
      @(negedge CLOCK_50); drive(OP_ADD, 4'd8, 4'd0, 1'b1, 16'h0002, 1'b1);
      chk("b2b.busy", 32'(busy), 32'd1);
      @(negedge CLOCK_50); op_valid = 1'b0;
      chk("b2b.d1", 32'(done), 32'd1);
      @(negedge CLOCK_50);
      chk("b2b.d2", 32'(done), 32'd0);
      @(negedge CLOCK_50);
      chk("b2b.d3", 32'(done), 32'd0);
      rd_reg("b2b.r7", 4'd7, 16'h0001);
      rd_reg("b2b.r8", 4'd8, 16'h0000);
    end else begin
      one_op("seed1", OP_ADD, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b1, 16'h0000, 16'h0001);
      @(negedge CLOCK_50); drive(OP_ADD, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b1);
      @(negedge CLOCK_50); drive(OP_ADD, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b1);
      chk("byp.busy", 32'(busy), 32'd0);
      @(negedge CLOCK_50); op_valid = 1'b0;
      chk("byp.a2", 32'(alu_a), 32'h0002);
      chk("byp.d1", 32'(done), 32'd1);
      @(negedge CLOCK_50);
      chk("byp.d2", 32'(done), 32'd1);
      @(negedge CLOCK_50);
      chk("byp.d3", 32'(done), 32'd0);
      rd_reg("byp.r1", 4'd1, 16'h0003);
    end

    // 6. reset during execute cycle of a write to r5
    @(negedge CLOCK_50); drive(OP_ADD, 4'd5, 4'd0, 1'b1, 16'h0009, 1'b1);
    @(negedge CLOCK_50); op_valid = 1'b0; reset_n = 1'b0;
    @(negedge CLOCK_50);
    chk("mid.done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    chk("mid.done2", 32'(done), 32'd0);
    rd_reg("mid.r5", 4'd5, 16'h0000);
    rd_reg("mid.r3", 4'd3, 16'h0000);
    chk("mid.res", 32'(result_out), 32'h0);
    one_op("post", OP_ADD, 4'd5, 4'd0, 1'b1, 16'h0003, 1'b1, 16'h0000, 16'h0003);
    rd_reg("post.r5", 4'd5, 16'h0003);
    chk("post.res", 32'(result_out), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
